// File: rtl/ref_read_arbiter_if.sv
// ref_read_arbiter_if
//   Bundles the engine-side request/stream signals, the DRAM reader
//   request/stream signals and the arbiter status outputs.
//   modport master : arbiter view (drives acknowledges, reader request,
//                    broadcast block stream, grant/busy/statistics)
//   modport slave  : environment view (engines + DRAM reader)
//   Per-engine fields are packed, engine e at [e*25 +: 25] / bit [e].
interface ref_read_arbiter_if #(
  parameter int NUM_ENGINES = 4,
  parameter int REF_LENGTH  = 128
);
  logic [NUM_ENGINES*25-1:0] eng_ref_addr_in;
  logic [NUM_ENGINES*25-1:0] eng_ref_length_in;
  logic [NUM_ENGINES-1:0]    eng_ref_info_valid_in;
  logic [NUM_ENGINES-1:0]    eng_ref_info_rdy_out;
  logic [2*REF_LENGTH-1:0]   eng_ref_seq_block_out;
  logic [NUM_ENGINES-1:0]    eng_ref_seq_block_valid_out;
  logic [NUM_ENGINES-1:0]    eng_ref_seq_block_rdy_in;
  logic [24:0]               rd_addr_out;
  logic [24:0]               rd_length_out;
  logic                      rd_info_valid_out;
  logic                      rd_info_rdy_in;
  logic [2*REF_LENGTH-1:0]   rd_block_in;
  logic                      rd_block_valid_in;
  logic                      rd_block_rdy_out;
  logic [3:0]                grant_out;
  logic                      busy_out;
  logic [31:0]               blocks_fwd_out;

  modport master (
    input  eng_ref_addr_in, eng_ref_length_in, eng_ref_info_valid_in,
           eng_ref_seq_block_rdy_in, rd_info_rdy_in, rd_block_in,
           rd_block_valid_in,
    output eng_ref_info_rdy_out, eng_ref_seq_block_out,
           eng_ref_seq_block_valid_out, rd_addr_out, rd_length_out,
           rd_info_valid_out, rd_block_rdy_out, grant_out, busy_out,
           blocks_fwd_out
  );

  modport slave (
    output eng_ref_addr_in, eng_ref_length_in, eng_ref_info_valid_in,
           eng_ref_seq_block_rdy_in, rd_info_rdy_in, rd_block_in,
           rd_block_valid_in,
    input  eng_ref_info_rdy_out, eng_ref_seq_block_out,
           eng_ref_seq_block_valid_out, rd_addr_out, rd_length_out,
           rd_info_valid_out, rd_block_rdy_out, grant_out, busy_out,
           blocks_fwd_out
  );
endinterface

// File: rtl/ref_read_arbiter.sv
// ref_read_arbiter
//   Round-robin arbiter sharing one DRAM reference reader among
//   NUM_ENGINES engines. A granted engine's (addr, length) request is
//   acknowledged, forwarded to the reader, and the returned blocks are
//   streamed back to that engine only (zero-latency ready/valid pass-through).
//   Ports:
//     clk  - system clock
//     rst  - synchronous reset, active low
//     bus  - ref_read_arbiter_if.master (engine requests/stream, reader
//            request/stream, grant_out, busy_out, blocks_fwd_out)
//   Build option: define REF_ARB_STATS_EN to enable the 32-bit forwarded
//   block counter on blocks_fwd_out; otherwise it is tied to zero.
module ref_read_arbiter #(
  parameter int NUM_ENGINES = 4,
  parameter int REF_LENGTH  = 128
) (
  input  logic                clk,
  input  logic                rst,
  ref_read_arbiter_if.master  bus
);

  typedef enum logic [1:0] {IDLE, ACK, ISSUE, STREAM} state_t;

  state_t                  state_q, state_d;
  logic [3:0]              grant_q, rr_ptr_q, pick_idx;
  logic                    pick_found;
  logic [24:0]             pick_addr, pick_len;
  logic [24:0]             addr_q, len_q, cnt_q;
  logic                    sel_blk_rdy, xfer;
  logic                    rd_info_valid, blk_rdy;
  logic [NUM_ENGINES-1:0]  info_rdy, blk_valid;
  logic [2*REF_LENGTH-1:0] blk_data;

  // First requester at or above rr_ptr, scanning with wrap-around.
  always_comb begin
    int unsigned idx;
    idx        = 0;
    pick_found = 1'b0;
    pick_idx   = '0;
    pick_addr  = '0;
    pick_len   = '0;
    for (int unsigned i = 0; i < NUM_ENGINES; i++) begin
      idx = (32'(rr_ptr_q) + i) % 32'(NUM_ENGINES);
      if (!pick_found && bus.eng_ref_info_valid_in[idx]) begin
        pick_found = 1'b1;
        pick_idx   = 4'(idx);
        pick_addr  = bus.eng_ref_addr_in[idx*25 +: 25];
        pick_len   = bus.eng_ref_length_in[idx*25 +: 25];
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    info_rdy      = '0;
    blk_valid     = '0;
    sel_blk_rdy   = 1'b0;
    rd_info_valid = 1'b0;
    blk_rdy       = 1'b0;
    xfer          = 1'b0;
    for (int unsigned e = 0; e < NUM_ENGINES; e++) begin
      if (grant_q == 4'(e)) sel_blk_rdy = bus.eng_ref_seq_block_rdy_in[e];
    end
    case (state_q)
      IDLE: begin
        if (pick_found) state_d = ACK;
      end
      ACK: begin
        for (int unsigned e = 0; e < NUM_ENGINES; e++) begin
          info_rdy[e] = (grant_q == 4'(e));
        end
        state_d = (len_q != '0) ? ISSUE : IDLE;
      end
      ISSUE: begin
        rd_info_valid = 1'b1;
        if (bus.rd_info_rdy_in) state_d = STREAM;
      end
      STREAM: begin
        for (int unsigned e = 0; e < NUM_ENGINES; e++) begin
          blk_valid[e] = (grant_q == 4'(e)) && bus.rd_block_valid_in;
        end
        blk_rdy = sel_blk_rdy;
        xfer    = bus.rd_block_valid_in && sel_blk_rdy;
        if (xfer && (cnt_q == len_q - 25'd1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      grant_q  <= '0;
      addr_q   <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && pick_found) begin
        grant_q <= pick_idx;
        addr_q  <= pick_addr;
        len_q   <= pick_len;
      end
      if (state_q == ISSUE && bus.rd_info_rdy_in) cnt_q <= '0;
      else if (xfer)                              cnt_q <= cnt_q + 25'd1;
      // Covers both the normal end of stream and the zero-length ACK exit.
      if (state_q != IDLE && state_d == IDLE) begin
        rr_ptr_q <= (grant_q == 4'(NUM_ENGINES - 1)) ? '0 : grant_q + 4'd1;
      end
    end
  end

`ifdef REF_ARB_STATS_EN
  logic [31:0] stats_q;
  always_ff @(posedge clk) begin
    if (!rst)      stats_q <= '0;
    else if (xfer) stats_q <= stats_q + 32'd1;
  end
  assign bus.blocks_fwd_out = stats_q;
`else
  assign bus.blocks_fwd_out = '0;
`endif

  assign blk_data                        = bus.rd_block_in;
  assign bus.eng_ref_seq_block_out       = blk_data;
  assign bus.eng_ref_info_rdy_out        = info_rdy;
  assign bus.eng_ref_seq_block_valid_out = blk_valid;
  assign bus.rd_addr_out                 = addr_q;
  assign bus.rd_length_out               = len_q;
  assign bus.rd_info_valid_out           = rd_info_valid;
  assign bus.rd_block_rdy_out            = blk_rdy;
  assign bus.grant_out                   = grant_q;
  assign bus.busy_out                    = (state_q != IDLE);

endmodule

// File: tb/tb_ref_read_arbiter.sv
module tb_ref_read_arbiter;
  localparam int NE = 4;
  localparam int RL = 128;
  localparam int BW = 2 * RL;
`ifdef REF_ARB_STATS_EN
  localparam logic [31:0] STATS_EXP = 32'd10;
`else
  localparam logic [31:0] STATS_EXP = 32'd0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ref_read_arbiter_if #(.NUM_ENGINES(NE), .REF_LENGTH(RL)) bus ();
  ref_read_arbiter #(.NUM_ENGINES(NE), .REF_LENGTH(RL)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  typedef struct { int eng; logic [BW-1:0] data; } blk_t;
  typedef struct { logic [24:0] addr; logic [24:0] len; } req_t;

  int   tests = 0;
  int   fails = 0;
  blk_t exp_blk_q[$];
  req_t exp_req_q[$];
  int   ack_log[$];
  int   popped = 0;
  bit   bubble_en = 1'b0;

  function automatic logic [BW-1:0] mkdata(logic [24:0] a, int k);
    logic [BW-1:0] d;
    for (int j = 0; j < BW / 32; j++)
      d[j*32 +: 32] = {7'd0, a} ^ (32'(k) << 8) ^ (32'(j) * 32'h01010101) ^ 32'hA500_0000;
    return d;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_xfer(int e, logic [24:0] a, logic [24:0] l);
    req_t r;
    blk_t b;
    r.addr = a;
    r.len  = l;
    if (l != 0) exp_req_q.push_back(r);
    for (int k = 0; k < int'(l); k++) begin
      b.eng  = e;
      b.data = mkdata(a, k);
      exp_blk_q.push_back(b);
    end
  endtask

  task automatic set_req(int e, logic [24:0] a, logic [24:0] l);
    bus.eng_ref_addr_in[e*25 +: 25]   = a;
    bus.eng_ref_length_in[e*25 +: 25] = l;
    bus.eng_ref_info_valid_in[e]      = 1'b1;
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      tick();
      if (bus.busy_out === 1'b0 && exp_blk_q.size() == 0 && exp_req_q.size() == 0 &&
          bus.eng_ref_info_valid_in == '0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Engines: observe acknowledges and drop the request after one.
  initial begin
    logic [NE-1:0] acked;
    forever begin
      @(negedge clk);
      acked = '0;
      if (rst === 1'b1) begin
        for (int e = 0; e < NE; e++) begin
          if (bus.eng_ref_info_rdy_out[e] === 1'b1) begin
            tests++;
            if (bus.eng_ref_info_valid_in[e] !== 1'b1) begin
              fails++;
              $display("FAIL ack_without_req: rdy_out[%0d]=1 while valid_in=%b, required no ack", e, bus.eng_ref_info_valid_in[e]);
            end
            ack_log.push_back(e);
            acked[e] = 1'b1;
          end
        end
      end
      @(posedge clk);
      #1;
      bus.eng_ref_info_valid_in = bus.eng_ref_info_valid_in & ~acked;
    end
  end

  // DRAM reader model: checks requests against the scoreboard and returns blocks.
  initial begin
    int          rem, k;
    logic [24:0] ra, rlen;
    bit          fi, fb, rs;
    req_t        r;
    rem = 0; k = 0; ra = '0; rlen = '0;
    bus.rd_info_rdy_in    = 1'b1;
    bus.rd_block_valid_in = 1'b0;
    bus.rd_block_in       = '0;
    forever begin
      @(negedge clk);
      rs = (rst === 1'b1);
      fi = rs && bus.rd_info_valid_out === 1'b1 && bus.rd_info_rdy_in === 1'b1;
      fb = rs && bus.rd_block_valid_in === 1'b1 && bus.rd_block_rdy_out === 1'b1;
      if (fi) begin
        ra   = bus.rd_addr_out;
        rlen = bus.rd_length_out;
        tests++;
        if (exp_req_q.size() == 0) begin
          fails++;
          $display("FAIL rd_request: got addr=%h len=%0d, required no request", ra, rlen);
        end else begin
          r = exp_req_q.pop_front();
          if (ra !== r.addr || rlen !== r.len) begin
            fails++;
            $display("FAIL rd_request: got addr=%h len=%0d, required addr=%h len=%0d", ra, rlen, r.addr, r.len);
          end
        end
      end
      @(posedge clk);
      #1;
      if (!rs) begin
        rem = 0;
      end else begin
        if (fb) begin rem--; k++; end
        if (fi) begin rem = int'(rlen); k = 0; end
      end
      bus.rd_block_valid_in = (rem > 0) && !(bubble_en && $urandom_range(0, 3) == 0);
      bus.rd_block_in       = (rem > 0) ? mkdata(ra, k) : '0;
    end
  end

  // Block stream scoreboard consumer.
  always @(negedge clk) begin
    int e;
    if (rst === 1'b1) begin
      if (bus.rd_block_valid_in === 1'b1 && exp_blk_q.size() > 0) begin
        e = exp_blk_q[0].eng;
        tests++;
        if (bus.eng_ref_seq_block_valid_out !== NE'(1 << e)) begin
          fails++;
          $display("FAIL blk_valid_route: got %b, required %b", bus.eng_ref_seq_block_valid_out, NE'(1 << e));
        end
        tests++;
        if (bus.rd_block_rdy_out !== bus.eng_ref_seq_block_rdy_in[e]) begin
          fails++;
          $display("FAIL blk_rdy_route: got %b, required %b", bus.rd_block_rdy_out, bus.eng_ref_seq_block_rdy_in[e]);
        end
        if (bus.rd_block_rdy_out === 1'b1) begin
          tests++;
          if (bus.eng_ref_seq_block_out !== exp_blk_q[0].data) begin
            fails++;
            $display("FAIL blk_data: got %h, required %h", bus.eng_ref_seq_block_out, exp_blk_q[0].data);
          end
          void'(exp_blk_q.pop_front());
          popped++;
        end
      end else if (bus.eng_ref_seq_block_valid_out !== '0) begin
        tests++;
        fails++;
        $display("FAIL blk_valid_spurious: got %b, required 0", bus.eng_ref_seq_block_valid_out);
      end
    end
  end

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) tick();
    bus.eng_ref_info_valid_in[1] = 1'b1;
    tick();
    tests++; if (bus.busy_out !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b required 0", bus.busy_out); end
    tests++; if (bus.grant_out !== 4'd0) begin fails++; $display("FAIL reset_grant: got %0d required 0", bus.grant_out); end
    tests++; if (bus.eng_ref_info_rdy_out !== '0) begin fails++; $display("FAIL reset_info_rdy: got %b required 0", bus.eng_ref_info_rdy_out); end
    tests++; if (bus.rd_info_valid_out !== 1'b0) begin fails++; $display("FAIL reset_rd_info_valid: got %b required 0", bus.rd_info_valid_out); end
    tests++; if (bus.eng_ref_seq_block_valid_out !== '0) begin fails++; $display("FAIL reset_blk_valid: got %b required 0", bus.eng_ref_seq_block_valid_out); end
    tests++; if (bus.rd_block_rdy_out !== 1'b0) begin fails++; $display("FAIL reset_blk_rdy: got %b required 0", bus.rd_block_rdy_out); end
    tests++; if (bus.blocks_fwd_out !== 32'd0) begin fails++; $display("FAIL reset_stats: got %0d required 0", bus.blocks_fwd_out); end
    bus.eng_ref_info_valid_in = '0;
    rst = 1'b1;
    tick();
  endtask

  task automatic test_single();
    bit ok;
    ack_log.delete();
    expect_xfer(2, 25'h100, 25'd3);
    set_req(2, 25'h100, 25'd3);
    tick();
    tests++; if (bus.busy_out !== 1'b1) begin fails++; $display("FAIL single_busy: got %b required 1", bus.busy_out); end
    tests++; if (bus.grant_out !== 4'd2) begin fails++; $display("FAIL single_grant: got %0d required 2", bus.grant_out); end
    tests++; if (bus.eng_ref_info_rdy_out !== 4'b0100) begin fails++; $display("FAIL single_ack: got %b required 0100", bus.eng_ref_info_rdy_out); end
    tick();
    tests++; if (bus.rd_info_valid_out !== 1'b1) begin fails++; $display("FAIL single_issue_latency: got %b required 1", bus.rd_info_valid_out); end
    tests++; if (bus.eng_ref_info_rdy_out !== '0) begin fails++; $display("FAIL single_ack_len: got %b required 0", bus.eng_ref_info_rdy_out); end
    wait_idle(60, ok);
    tests++; if (!ok) begin fails++; $display("FAIL single_done: got timeout, required idle with %0d blocks left", exp_blk_q.size()); end
    tests++; if (ack_log.size() != 1) begin fails++; $display("FAIL single_ack_count: got %0d required 1", ack_log.size()); end
  endtask

  task automatic test_wrap();
    bit ok;
    ack_log.delete();
    expect_xfer(3, 25'h200, 25'd2);
    expect_xfer(0, 25'h300, 25'd1);
    set_req(0, 25'h300, 25'd1);
    set_req(3, 25'h200, 25'd2);
    wait_idle(100, ok);
    tests++; if (!ok) begin fails++; $display("FAIL wrap_done: got timeout, required idle"); end
    tests++;
    if (ack_log.size() != 2 || ack_log[0] != 3 || ack_log[1] != 0) begin
      fails++; $display("FAIL wrap_order: got %p required '{3, 0}", ack_log);
    end
  endtask

  task automatic test_rr();
    bit ok;
    ack_log.delete();
    bubble_en = 1'b1;
    expect_xfer(1, 25'h400, 25'd2);
    expect_xfer(3, 25'h500, 25'd3);
    expect_xfer(0, 25'h600, 25'd1);
    set_req(0, 25'h600, 25'd1);
    set_req(1, 25'h400, 25'd2);
    set_req(3, 25'h500, 25'd3);
    wait_idle(300, ok);
    bubble_en = 1'b0;
    tests++; if (!ok) begin fails++; $display("FAIL rr_done: got timeout, required idle"); end
    tests++;
    if (ack_log.size() != 3 || ack_log[0] != 1 || ack_log[1] != 3 || ack_log[2] != 0) begin
      fails++; $display("FAIL rr_order: got %p required '{1, 3, 0}", ack_log);
    end
  endtask

  task automatic test_zero_len();
    bit ok;
    set_req(1, 25'h700, 25'd0);
    tick();
    tests++; if (bus.eng_ref_info_rdy_out !== 4'b0010) begin fails++; $display("FAIL zero_ack: got %b required 0010", bus.eng_ref_info_rdy_out); end
    tests++; if (bus.busy_out !== 1'b1) begin fails++; $display("FAIL zero_busy_ack: got %b required 1", bus.busy_out); end
    tick();
    tests++; if (bus.busy_out !== 1'b0) begin fails++; $display("FAIL zero_busy_after: got %b required 0", bus.busy_out); end
    tests++; if (bus.rd_info_valid_out !== 1'b0) begin fails++; $display("FAIL zero_no_issue: got %b required 0", bus.rd_info_valid_out); end
    tests++; if (bus.eng_ref_info_rdy_out !== '0) begin fails++; $display("FAIL zero_ack_len: got %b required 0", bus.eng_ref_info_rdy_out); end
    tick();
    ack_log.delete();
    expect_xfer(2, 25'h800, 25'd1);
    expect_xfer(1, 25'h900, 25'd1);
    set_req(1, 25'h900, 25'd1);
    set_req(2, 25'h800, 25'd1);
    wait_idle(100, ok);
    tests++; if (!ok) begin fails++; $display("FAIL zero_next_done: got timeout, required idle"); end
    tests++;
    if (ack_log.size() != 2 || ack_log[0] != 2 || ack_log[1] != 1) begin
      fails++; $display("FAIL zero_rr_advance: got %p required '{2, 1}", ack_log);
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    int base;
    base = popped;
    expect_xfer(0, 25'hA00, 25'd4);
    set_req(0, 25'hA00, 25'd4);
    ok = 1'b0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (popped == base + 2) begin ok = 1'b1; break; end
    end
    tests++; if (!ok) begin fails++; $display("FAIL bp_reach_mid: got %0d blocks, required 2", popped - base); end
    bus.eng_ref_seq_block_rdy_in[0] = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #2;
      tests++; if (bus.rd_block_rdy_out !== 1'b0) begin fails++; $display("FAIL bp_rdy_low: cycle %0d got %b required 0", c, bus.rd_block_rdy_out); end
      tests++; if (bus.busy_out !== 1'b1) begin fails++; $display("FAIL bp_busy: cycle %0d got %b required 1", c, bus.busy_out); end
      tests++; if (popped != base + 2) begin fails++; $display("FAIL bp_hold: cycle %0d got %0d blocks required 2", c, popped - base); end
      @(posedge clk);
      #1;
    end
    bus.eng_ref_seq_block_rdy_in[0] = 1'b1;
    wait_idle(60, ok);
    tests++; if (!ok) begin fails++; $display("FAIL bp_done: got timeout with %0d blocks left, required idle", exp_blk_q.size()); end
  endtask

  task automatic test_reset_midstream();
    bit ok;
    int base;
    base = popped;
    expect_xfer(3, 25'hB00, 25'd4);
    set_req(3, 25'hB00, 25'd4);
    ok = 1'b0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (popped == base + 2) begin ok = 1'b1; break; end
    end
    tests++; if (!ok) begin fails++; $display("FAIL rstmid_reach: got %0d blocks, required 2", popped - base); end
    rst = 1'b0;
    tick();
    tests++; if (bus.busy_out !== 1'b0) begin fails++; $display("FAIL rstmid_busy: got %b required 0", bus.busy_out); end
    tests++; if (bus.grant_out !== 4'd0) begin fails++; $display("FAIL rstmid_grant: got %0d required 0", bus.grant_out); end
    tests++; if (bus.eng_ref_seq_block_valid_out !== '0) begin fails++; $display("FAIL rstmid_blk_valid: got %b required 0", bus.eng_ref_seq_block_valid_out); end
    tests++; if (bus.rd_block_rdy_out !== 1'b0) begin fails++; $display("FAIL rstmid_blk_rdy: got %b required 0", bus.rd_block_rdy_out); end
    tests++; if (bus.rd_info_valid_out !== 1'b0) begin fails++; $display("FAIL rstmid_rd_info: got %b required 0", bus.rd_info_valid_out); end
    tests++; if (bus.blocks_fwd_out !== 32'd0) begin fails++; $display("FAIL rstmid_stats: got %0d required 0", bus.blocks_fwd_out); end
    exp_blk_q.delete();
    exp_req_q.delete();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_stats();
    bit ok;
    ack_log.delete();
    expect_xfer(1, 25'hC00, 25'd6);
    expect_xfer(2, 25'hD00, 25'd4);
    set_req(2, 25'hD00, 25'd4);
    set_req(1, 25'hC00, 25'd6);
    wait_idle(150, ok);
    tests++; if (!ok) begin fails++; $display("FAIL stats_done: got timeout, required idle"); end
    tests++;
    if (ack_log.size() != 2 || ack_log[0] != 1 || ack_log[1] != 2) begin
      fails++; $display("FAIL stats_order_after_reset: got %p required '{1, 2}", ack_log);
    end
    tests++; if (bus.blocks_fwd_out !== STATS_EXP) begin fails++; $display("FAIL stats_count: got %0d required %0d", bus.blocks_fwd_out, STATS_EXP); end
  endtask

  initial begin
    rst = 1'b0;
    bus.eng_ref_info_valid_in    = '0;
    bus.eng_ref_addr_in          = '0;
    bus.eng_ref_length_in        = '0;
    bus.eng_ref_seq_block_rdy_in = '1;
    test_reset();
    test_single();
    test_wrap();
    test_rr();
    test_zero_len();
    test_backpressure();
    test_reset_midstream();
    test_stats();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end
endmodule
